// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RISC-V architectural types shared with the trap sequencer
package riscv_pkg;

  typedef logic [4:0] xcpt_code_t;

  localparam xcpt_code_t XCPT_INSTR_MISALIGNED = 5'd0;
  localparam xcpt_code_t XCPT_INSTR_FAULT      = 5'd1;
  localparam xcpt_code_t XCPT_ILLEGAL_INSTR    = 5'd2;
  localparam xcpt_code_t XCPT_BREAKPOINT       = 5'd3;
  localparam xcpt_code_t XCPT_LOAD_MISALIGNED  = 5'd4;
  localparam xcpt_code_t XCPT_LOAD_FAULT       = 5'd5;
  localparam xcpt_code_t XCPT_STORE_MISALIGNED = 5'd6;
  localparam xcpt_code_t XCPT_STORE_FAULT      = 5'd7;
  localparam xcpt_code_t XCPT_ECALL_M          = 5'd11;

endpackage

// File: rtl/tartaruga_pkg.sv
// rtl/tartaruga_pkg.sv - trap sequencer states, defaults and trap record type
package tartaruga_pkg;

  localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRAP,
    ST_FLUSH,
    ST_REDIRECT,
    ST_MRET
  } trap_state_t;

  typedef struct packed {
    riscv_pkg::xcpt_code_t code;
    logic [31:0]           pc;
    logic [31:0]           tval;
  } trap_info_t;

endpackage

// File: rtl/trap_prio.sv
// rtl/trap_prio.sv - oldest-first (EX > ID > IF) exception select
module trap_prio
  import riscv_pkg::*;
  import tartaruga_pkg::*;
(
  input  logic        if_valid_i,
  input  xcpt_code_t  if_code_i,
  input  logic [31:0] if_pc_i,
  input  logic [31:0] if_tval_i,
  input  logic        id_valid_i,
  input  xcpt_code_t  id_code_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_tval_i,
  input  logic        ex_valid_i,
  input  xcpt_code_t  ex_code_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_tval_i,
  output logic        valid_o,
  output trap_info_t  info_o
);

  always_comb begin
    valid_o = 1'b0;
    info_o  = '0;
    if (ex_valid_i) begin
      valid_o = 1'b1;
      info_o  = '{code: ex_code_i, pc: ex_pc_i, tval: ex_tval_i};
    end else if (id_valid_i) begin
      valid_o = 1'b1;
      info_o  = '{code: id_code_i, pc: id_pc_i, tval: id_tval_i};
    end else if (if_valid_i) begin
      valid_o = 1'b1;
      info_o  = '{code: if_code_i, pc: if_pc_i, tval: if_tval_i};
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap/mret sequencer driving CSR capture, flush and fetch redirect
module trap_ctrl
  import riscv_pkg::*;
  import tartaruga_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_xcpt_i,
  input  logic        id_xcpt_i,
  input  logic        ex_xcpt_i,
  input  xcpt_code_t  if_xcpt_code_i,
  input  xcpt_code_t  id_xcpt_code_i,
  input  xcpt_code_t  ex_xcpt_code_i,
  input  logic [31:0] if_pc_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] if_tval_i,
  input  logic [31:0] id_tval_i,
  input  logic [31:0] ex_tval_i,
  input  logic        mret_i,
  input  logic [31:0] csr_mepc_i,
  input  logic        dec_csr_write_i,
  output logic        csr_write_o,
  output logic        xcpt_o,
  output xcpt_code_t  xcpt_code_o,
  output logic [31:0] xcpt_pc_o,
  output logic [31:0] xcpt_value_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  trap_state_t state_q;
  cnt_t        cnt_q;
  trap_info_t  info_q;
  logic        xcpt_q;
  logic        flush_q;
  logic        stall_q;
  logic        redir_q;
  logic [31:0] redir_pc_q;
  logic        busy_q;

  logic        prio_valid;
  trap_info_t  prio_info;
  logic        is_idle;
  logic        take_mret;
  logic        take_xcpt;

  trap_prio u_trap_prio (
    .if_valid_i (if_xcpt_i),
    .if_code_i  (if_xcpt_code_i),
    .if_pc_i    (if_pc_i),
    .if_tval_i  (if_tval_i),
    .id_valid_i (id_xcpt_i),
    .id_code_i  (id_xcpt_code_i),
    .id_pc_i    (id_pc_i),
    .id_tval_i  (id_tval_i),
    .ex_valid_i (ex_xcpt_i),
    .ex_code_i  (ex_xcpt_code_i),
    .ex_pc_i    (ex_pc_i),
    .ex_tval_i  (ex_tval_i),
    .valid_o    (prio_valid),
    .info_o     (prio_info)
  );

  // mret sits between EX and the younger stages in the age order.
  assign is_idle   = (state_q == ST_IDLE);
  assign take_mret = is_idle && mret_i && !ex_xcpt_i;
  assign take_xcpt = is_idle && prio_valid && !take_mret;

  assign csr_write_o = dec_csr_write_i && is_idle && !(prio_valid || mret_i);

  // Outputs are registered from the state being entered, so they line up with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      info_q     <= '0;
      xcpt_q     <= 1'b0;
      flush_q    <= 1'b0;
      stall_q    <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      xcpt_q     <= 1'b0;
      flush_q    <= 1'b0;
      stall_q    <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      busy_q     <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (take_mret) begin
            state_q    <= ST_MRET;
            flush_q    <= 1'b1;
            redir_q    <= 1'b1;
            redir_pc_q <= csr_mepc_i;
            busy_q     <= 1'b1;
          end else if (take_xcpt) begin
            state_q <= ST_TRAP;
            info_q  <= prio_info;
            xcpt_q  <= 1'b1;
            flush_q <= 1'b1;
            stall_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_TRAP: begin
          state_q <= ST_FLUSH;
          cnt_q   <= cnt_t'(FLUSH_CYCLES);
          flush_q <= 1'b1;
          stall_q <= 1'b1;
        end
        ST_FLUSH: begin
          cnt_q   <= (cnt_q != '0) ? cnt_q - cnt_t'(1) : cnt_q;
          stall_q <= 1'b1;
          if (cnt_q == cnt_t'(1)) begin
            state_q    <= ST_REDIRECT;
            redir_q    <= 1'b1;
            redir_pc_q <= TRAP_VECTOR;
          end else begin
            flush_q <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        ST_MRET: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign xcpt_o           = xcpt_q;
  assign xcpt_code_o      = info_q.code;
  assign xcpt_pc_o        = info_q.pc;
  assign xcpt_value_o     = info_q.tval;
  assign flush_o          = flush_q;
  assign stall_o          = stall_q;
  assign redirect_valid_o = redir_q;
  assign redirect_pc_o    = redir_pc_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - randomized bench for trap_ctrl against a cycle-schedule model
module tb_trap_ctrl;

  localparam int          FC = 2;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int          N  = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifx, idx, exx;
  logic [4:0]  ifc, idc, exc;
  logic [31:0] ifpc, idpc, expc, iftv, idtv, extv;
  logic        mret;
  logic [31:0] mepc;
  logic        dec;

  logic        csr_write_o, xcpt_o, flush_o, stall_o, redirect_valid_o, busy_o;
  logic [4:0]  xcpt_code_o;
  logic [31:0] xcpt_pc_o, xcpt_value_o, redirect_pc_o;

  always #5 clk = ~clk;

  trap_ctrl #(.TRAP_VECTOR(TV), .FLUSH_CYCLES(FC)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .if_xcpt_i        (ifx),
    .id_xcpt_i        (idx),
    .ex_xcpt_i        (exx),
    .if_xcpt_code_i   (ifc),
    .id_xcpt_code_i   (idc),
    .ex_xcpt_code_i   (exc),
    .if_pc_i          (ifpc),
    .id_pc_i          (idpc),
    .ex_pc_i          (expc),
    .if_tval_i        (iftv),
    .id_tval_i        (idtv),
    .ex_tval_i        (extv),
    .mret_i           (mret),
    .csr_mepc_i       (mepc),
    .dec_csr_write_i  (dec),
    .csr_write_o      (csr_write_o),
    .xcpt_o           (xcpt_o),
    .xcpt_code_o      (xcpt_code_o),
    .xcpt_pc_o        (xcpt_pc_o),
    .xcpt_value_o     (xcpt_value_o),
    .flush_o          (flush_o),
    .stall_o          (stall_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .busy_o           (busy_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;

  // Expected outputs indexed by absolute cycle number.
  bit          e_xcpt[N], e_flush[N], e_stall[N], e_redir[N], e_busy[N];
  logic [4:0]  e_code[N];
  logic [31:0] e_pc[N], e_tval[N], e_rpc[N];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle=%0d obs=%h exp=%h", tag, t, obs, exp);
  endtask

  task automatic schedule_trap(input logic [4:0] c, input logic [31:0] pc, input logic [31:0] tv);
    e_xcpt[t+1] = 1'b1;
    e_code[t+1] = c;
    e_pc[t+1]   = pc;
    e_tval[t+1] = tv;
    for (int k = 1; k <= FC + 1; k++) e_flush[t+k] = 1'b1;
    for (int k = 1; k <= FC + 2; k++) begin
      e_stall[t+k] = 1'b1;
      e_busy[t+k]  = 1'b1;
    end
    e_redir[t+FC+2] = 1'b1;
    e_rpc[t+FC+2]   = TV;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; ifx = 1'b0; idx = 1'b0; exx = 1'b0; mret = 1'b0; dec = 1'b0;
  endtask

  // Inputs are already applied; check this cycle, update the schedule, advance.
  task automatic step();
    bit idle;
    bit any;
    @(negedge clk);
    idle = !e_busy[t];
    any  = ifx || idx || exx || mret;
    check_eq("csr_write", csr_write_o, dec && idle && !any);
    check_eq("busy", busy_o, e_busy[t]);
    check_eq("xcpt", xcpt_o, e_xcpt[t]);
    check_eq("flush", flush_o, e_flush[t]);
    check_eq("stall", stall_o, e_stall[t]);
    check_eq("redirect", redirect_valid_o, e_redir[t]);
    if (e_xcpt[t]) begin
      check_eq("xcpt_code", xcpt_code_o, e_code[t]);
      check_eq("xcpt_pc", xcpt_pc_o, e_pc[t]);
      check_eq("xcpt_tval", xcpt_value_o, e_tval[t]);
    end
    if (e_redir[t]) check_eq("redirect_pc", redirect_pc_o, e_rpc[t]);
    if (rst) begin
      for (int k = 1; k <= 8; k++) begin
        e_xcpt[t+k] = 1'b0; e_flush[t+k] = 1'b0; e_stall[t+k] = 1'b0;
        e_redir[t+k] = 1'b0; e_busy[t+k] = 1'b0;
      end
    end else if (idle) begin
      if (exx) schedule_trap(exc, expc, extv);
      else if (mret) begin
        e_flush[t+1] = 1'b1;
        e_redir[t+1] = 1'b1;
        e_rpc[t+1]   = mepc;
        e_busy[t+1]  = 1'b1;
      end
      else if (idx) schedule_trap(idc, idpc, idtv);
      else if (ifx) schedule_trap(ifc, ifpc, iftv);
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    ifc = '0; idc = '0; exc = '0;
    ifpc = '0; idpc = '0; expc = '0; iftv = '0; idtv = '0; extv = '0; mepc = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ctrl", {26'd0, xcpt_o, flush_o, stall_o, redirect_valid_o, busy_o, csr_write_o}, 32'd0);
    check_eq("rst_code", xcpt_code_o, 32'd0);
    check_eq("rst_pc", xcpt_pc_o, 32'd0);
    check_eq("rst_tval", xcpt_value_o, 32'd0);
    check_eq("rst_rpc", redirect_pc_o, 32'd0);
    rst = 1'b0;

    // Single ID exception.
    idx = 1'b1; idc = 5'd2; idpc = 32'h40; idtv = 32'hDEAD_BEEF;
    step(); clear_inputs(); repeat (6) step();

    // All three stages fault together: EX wins.
    ifx = 1'b1; ifc = 5'd0;  ifpc = 32'h48;
    idx = 1'b1; idc = 5'd2;  idpc = 32'h44;
    exx = 1'b1; exc = 5'd11; expc = 32'h40; extv = 32'h0;
    step(); clear_inputs(); repeat (6) step();

    // mret alone, then mret with an EX exception.
    mret = 1'b1; mepc = 32'h200;
    step(); clear_inputs(); repeat (3) step();
    mret = 1'b1; exx = 1'b1; exc = 5'd7; expc = 32'h80; extv = 32'h1234;
    step(); clear_inputs(); repeat (6) step();

    // CSR write held high across an exception.
    dec = 1'b1; repeat (2) step();
    exx = 1'b1; exc = 5'd5; expc = 32'h90;
    step(); clear_inputs(); dec = 1'b1; repeat (7) step();
    dec = 1'b0;

    // Exceptions and mret during FLUSH are ignored.
    idx = 1'b1; idc = 5'd3; idpc = 32'hA0; idtv = 32'h5;
    step(); clear_inputs(); step();
    exx = 1'b1; idx = 1'b1; ifx = 1'b1; mret = 1'b1;
    step(); clear_inputs(); repeat (6) step();

    // Reset in FLUSH, then a fresh exception.
    exx = 1'b1; exc = 5'd4; expc = 32'hB0; extv = 32'h77;
    step(); clear_inputs(); step();
    rst = 1'b1;
    step(); clear_inputs(); repeat (2) step();
    ifx = 1'b1; ifc = 5'd1; ifpc = 32'hC0; iftv = 32'h99;
    step(); clear_inputs(); repeat (6) step();

    repeat (2000) begin
      rst  = ($urandom_range(0, 63) == 0);
      ifx  = ($urandom_range(0, 7) == 0);
      idx  = ($urandom_range(0, 7) == 0);
      exx  = ($urandom_range(0, 9) == 0);
      mret = ($urandom_range(0, 11) == 0);
      dec  = $urandom_range(0, 1) == 1;
      ifc  = 5'($urandom_range(0, 31)); idc = 5'($urandom_range(0, 31)); exc = 5'($urandom_range(0, 31));
      ifpc = $urandom; idpc = $urandom; expc = $urandom;
      iftv = $urandom; idtv = $urandom; extv = $urandom;
      mepc = $urandom;
      step();
    end
    clear_inputs();
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer between the pipeline stages and the CSR register file. It collects exception reports from fetch, decode and execute, and selects the oldest one. It then drives the CSR file's exception-capture port for exactly one cycle, flushes the pipeline and redirects fetch to the trap vector. It also sequences `mret`, returning fetch to the saved `mepc`, and gates decode's CSR writes so that no write commits while a trap is in flight.

## Interface
Parameters:
- `TRAP_VECTOR`, default 32'h0000_0100: fixed trap handler address.
- `FLUSH_CYCLES`, default 2: extra flush cycles after the trap cycle; must be ≥1.

Ports:
- `clk_i`  in  1  clock. One clock domain; all logic on its rising edge.
- `rst_i`  in  1  synchronous reset, active-high.
- `if_xcpt_i` / `id_xcpt_i` / `ex_xcpt_i`  in  1  exception valid, per stage.
- `if_xcpt_code_i` / `id_xcpt_code_i` / `ex_xcpt_code_i`  in  xcpt_code_t (5)  cause code.
- `if_pc_i` / `id_pc_i` / `ex_pc_i`  in  32  PC of the faulting instruction.
- `if_tval_i` / `id_tval_i` / `ex_tval_i`  in  32  trap value.
- `mret_i`  in  1  `mret` reached execute.
- `csr_mepc_i`  in  32  current `mepc` from the CSR file.
- `dec_csr_write_i`  in  1  decode requests a CSR write.
- `csr_write_o`  out  1  gated CSR write enable to the CSR file.
- `xcpt_o`  out  1  exception capture strobe to the CSR file.
- `xcpt_code_o`  out  xcpt_code_t  captured cause.
- `xcpt_pc_o`  out  32  captured PC.
- `xcpt_value_o`  out  32  captured tval.
- `flush_o`  out  1  kill all in-flight instructions.
- `stall_o`  out  1  freeze fetch/decode.
- `redirect_valid_o`  out  1  one-cycle fetch redirect strobe.
- `redirect_pc_o`  out  32  redirect target.
- `busy_o`  out  1  state ≠ IDLE.

## Operation
States: IDLE, TRAP, FLUSH, REDIRECT, MRET.

- **IDLE**
  - Priority is EX > ID > IF (oldest first). `mret_i` ranks below an EX exception and above ID/IF exceptions.
  - Exception accepted: latch code/pc/tval of the winner; next state TRAP.
  - `mret_i` accepted: latch `csr_mepc_i`; next state MRET.
  - `csr_write_o` = `dec_csr_write_i` && nothing accepted this cycle.
- **TRAP**
  - Outputs: `xcpt_o`=1 with the latched fields, `flush_o`=1, `stall_o`=1.
  - Loads the counter with `FLUSH_CYCLES`; next state FLUSH.
- **FLUSH**
  - Outputs: `flush_o`=1, `stall_o`=1.
  - Counter decrements each cycle; at 1, next state REDIRECT.
- **REDIRECT**
  - Outputs: `redirect_valid_o`=1, `redirect_pc_o`=`TRAP_VECTOR`, `stall_o`=1; next state IDLE.
- **MRET**
  - Outputs: `flush_o`=1, `redirect_valid_o`=1, `redirect_pc_o`=latched mepc; next state IDLE.
- In all states other than IDLE:
  - All exception and `mret_i` inputs are ignored; they belong to flushed instructions.
  - `csr_write_o`=0.
- Counter width is $clog2(FLUSH_CYCLES+1); it never wraps.
- `xcpt_code_o` is 5 bits; the CSR file zero-extends it into `mcause`.

## Timing
- Reset values: state IDLE, counter 0, latches 0. Every output is 0; `csr_write_o` is still the combinational IDLE gate.
- Reset is synchronous: asserting `rst_i` in any state returns to IDLE on the next edge. No partial redirect or `xcpt_o` is issued after reset.
- Exception at cycle T (IDLE):
  - `xcpt_o` at T+1, for exactly one cycle.
  - `flush_o` over T+1 .. T+1+FLUSH_CYCLES.
  - `redirect_valid_o` at T+2+FLUSH_CYCLES.
  - Back in IDLE at T+3+FLUSH_CYCLES.
- `mret` at T: redirect to mepc at T+1; IDLE at T+2.
- Simultaneous events:
  - Multiple exceptions: the oldest wins and the others are dropped.
  - EX exception plus `mret`: the exception wins.
  - Exception plus CSR write at T: the write is blocked.
- Back-to-back: a new exception can be accepted on the first IDLE cycle after REDIRECT or MRET.

## Structure
- `tartaruga_pkg` holds:
  - `trap_state_t` enum;
  - `TRAP_VECTOR_DEFAULT`;
  - `trap_info_t` struct {code, pc, tval}.
- `riscv_pkg` supplies `xcpt_code_t`.
- One sub-module, `trap_prio`: combinational three-way oldest-first select that returns valid plus `trap_info_t`.

## Test plan
- Single ID exception (code 2, pc 0x40, tval 0xDEAD_BEEF) at T, FLUSH_CYCLES=2:
  - `xcpt_o` at T+1 with exactly those fields;
  - `flush_o` over T+1..T+3;
  - redirect to 0x100 at T+4;
  - `busy_o` low at T+5.
- IF (code 0, pc 0x48) + ID (code 2, pc 0x44) + EX (code 11, pc 0x40) in the same cycle: captures code 11, pc 0x40.
- `mret_i` with `csr_mepc_i`=0x200 at T: redirect to 0x200 with `flush_o` at T+1; IDLE at T+2. Repeat with a simultaneous EX exception: the trap path is taken and no mepc redirect occurs.
- `dec_csr_write_i` held high:
  - passes through in IDLE;
  - 0 in the cycle an exception is accepted and during TRAP/FLUSH/REDIRECT;
  - restored on return to IDLE.
- Exceptions and `mret_i` pulsed during FLUSH: ignored, no second `xcpt_o`.
- `rst_i` pulsed while in FLUSH: all outputs 0 on the next cycle; no redirect issued; a new exception afterwards is handled normally.
